// File: rtl/usb_packet_pkg.sv
// Shared USB packet definitions: PIDs, CRC16 constants, transmit FSM states
// and the byte-wise CRC16 step shared by the TX framer and the RX checker.
package usb_packet_pkg;

   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;
   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;

   localparam logic [15:0] CRC16_POLY      = 16'h8005;
   localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
   localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
   localparam logic [15:0] CRC16_RESIDUAL  = 16'hB001;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND_PID,
      ST_SEND_DATA,
      ST_SEND_CRC_LO,
      ST_SEND_CRC_HI,
      ST_WAIT_HS
   } tx_state_e;

   // PID byte on the wire is the 4-bit PID with its complement in the upper nibble
   function automatic logic [7:0] pid_byte(input logic [3:0] pid);
      return {~pid, pid};
   endfunction

   // One byte of the reflected CRC16, consuming data bits LSB first
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
      logic [15:0] c;
      c = crc ^ {8'h00, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC16_POLY_REFL) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/usb_crc16.sv
// Byte-wise USB CRC16 engine: clear loads the init value, update folds in one
// byte. The raw register is exposed; the framer inverts it before sending.
module usb_crc16
   import usb_packet_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        clear_i,
   input  logic        update_i,
   input  logic [7:0]  data_i,
   output logic [15:0] crc_o
);

   logic [15:0] crc_d;
   logic [15:0] crc_q;

   // Next CRC value: clear takes priority over a data update
   always_comb begin
      crc_d = crc_q;
      if (clear_i) begin
         crc_d = CRC16_INIT;
      end else if (update_i) begin
         crc_d = crc16_byte(crc_q, data_i);
      end
   end

   // CRC register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         crc_q <= CRC16_INIT;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/usb_in_packet_gen.sv
// IN packet framer: on an accepted IN token streams PID, payload popped from
// the EP IN FIFO and CRC16 to the serializer, then commits or rolls back the
// FIFO pop transaction depending on the host handshake. Owns the data toggle.
module usb_in_packet_gen
   import usb_packet_pkg::*;
#(
   parameter int MAX_PACKET_SIZE = 64
) (
   input  logic       clk12_i,
   input  logic       rst_n_i,
   input  logic       start_i,
   input  logic       ack_i,
   input  logic       timeout_i,
   input  logic       toggleReset_i,
   input  logic       fifoDataAvailable_i,
   input  logic [7:0] fifoData_i,
   output logic       fifoPop_o,
   output logic       fifoPopTransDone_o,
   output logic       fifoPopTransSuccess_o,
   output logic       txValid_o,
   output logic [7:0] txData_o,
   output logic       txIsLast_o,
   input  logic       txReady_i,
   output logic       busy_o,
   output logic       dataToggle_o
);

   localparam int CNT_WID = $clog2(MAX_PACKET_SIZE + 1);
   localparam logic [CNT_WID-1:0] CNT_MAX = CNT_WID'(MAX_PACKET_SIZE);

   tx_state_e          state_q, state_d;
   logic [CNT_WID-1:0] count_q, count_d;
   logic               toggle_q, toggle_d;
   logic               pid_toggle_q, pid_toggle_d;
   logic               done_q, done_d;
   logic               success_q, success_d;

   logic               tx_valid;
   logic [7:0]         tx_data;
   logic               tx_last;
   logic               tx_accept;
   logic               data_avail;
   logic               crc_clear;
   logic [15:0]        crc_raw;
   logic [15:0]        crc_out;

   // Payload CRC: restarted when the PID is accepted, fed by every popped byte
   usb_crc16 u_crc (
      .clk_i    (clk12_i),
      .rst_n_i  (rst_n_i),
      .clear_i  (crc_clear),
      .update_i (fifoPop_o),
      .data_i   (fifoData_i),
      .crc_o    (crc_raw)
   );

   assign crc_out = ~crc_raw;

   // Transmit mux: what is offered to the serializer in each state
   always_comb begin
      tx_valid   = 1'b0;
      tx_data    = 8'h00;
      tx_last    = 1'b0;
      data_avail = fifoDataAvailable_i && (count_q < CNT_MAX);
      case (state_q)
         ST_SEND_PID: begin
            tx_valid = 1'b1;
            tx_data  = pid_byte(pid_toggle_q ? PID_DATA1 : PID_DATA0);
         end
         ST_SEND_DATA: begin
            if (data_avail) begin
               tx_valid = 1'b1;
               tx_data  = fifoData_i;
            end
         end
         ST_SEND_CRC_LO: begin
            tx_valid = 1'b1;
            tx_data  = crc_out[7:0];
         end
         ST_SEND_CRC_HI: begin
            tx_valid = 1'b1;
            tx_data  = crc_out[15:8];
            tx_last  = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign tx_accept = tx_valid && txReady_i;
   assign fifoPop_o = (state_q == ST_SEND_DATA) && tx_accept;
   assign crc_clear = (state_q == ST_SEND_PID) && tx_accept;

   // Next-state, counter, toggle and handshake-result logic
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      toggle_d     = toggle_q;
      pid_toggle_d = pid_toggle_q;
      done_d       = 1'b0;
      success_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d      = ST_SEND_PID;
               pid_toggle_d = toggleReset_i ? 1'b0 : toggle_q;
            end
         end
         ST_SEND_PID: begin
            if (tx_accept) begin
               count_d = '0;
               state_d = ST_SEND_DATA;
            end
         end
         ST_SEND_DATA: begin
            if (!data_avail) begin
               state_d = ST_SEND_CRC_LO;
            end else if (tx_accept) begin
               count_d = count_q + 1'b1;
            end
         end
         ST_SEND_CRC_LO: begin
            if (tx_accept) begin
               state_d = ST_SEND_CRC_HI;
            end
         end
         ST_SEND_CRC_HI: begin
            if (tx_accept) begin
               state_d = ST_WAIT_HS;
            end
         end
         ST_WAIT_HS: begin
            if (ack_i) begin
               done_d    = 1'b1;
               success_d = 1'b1;
               toggle_d  = ~toggle_q;
               state_d   = ST_IDLE;
            end else if (timeout_i) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (toggleReset_i) begin
         toggle_d = 1'b0;
      end
   end

   // FSM and status registers
   always_ff @(posedge clk12_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= ST_IDLE;
         count_q      <= '0;
         toggle_q     <= 1'b0;
         pid_toggle_q <= 1'b0;
         done_q       <= 1'b0;
         success_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         toggle_q     <= toggle_d;
         pid_toggle_q <= pid_toggle_d;
         done_q       <= done_d;
         success_q    <= success_d;
      end
   end

   assign txValid_o             = tx_valid;
   assign txData_o              = tx_data;
   assign txIsLast_o            = tx_last;
   assign fifoPopTransDone_o    = done_q;
   assign fifoPopTransSuccess_o = success_q;
   assign busy_o                = (state_q != ST_IDLE);
   assign dataToggle_o          = toggle_q;

endmodule

// File: tb/tb_usb_in_packet_gen.sv
// Self-checking bench for usb_in_packet_gen: a transactional FIFO model feeds
// the DUT, expected wire bytes are queued per packet and compared as the
// serializer accepts them.
module tb_usb_in_packet_gen;

   localparam int TB_MAX = 64;

   logic       clock = 1'b0;
   logic       rst_n;
   logic       startIn;
   logic       ackIn;
   logic       timeoutIn;
   logic       toggleResetIn;
   logic       fifoAvail;
   logic [7:0] fifoData;
   logic       fifoPop;
   logic       transDone;
   logic       transSuccess;
   logic       txValid;
   logic [7:0] txData;
   logic       txLast;
   logic       txReady;
   logic       busy;
   logic       dataToggle;

   int         checkCount = 0;
   int         passCount = 0;

   logic [7:0] fifoMem [0:255];
   int         rdPtr = 0;
   int         wrPtr = 0;
   int         transStart = 0;
   bit         fifoFlush = 1'b0;
   bit         popSeen = 1'b0;
   bit         doneSeen = 1'b0;
   bit         successSeen = 1'b0;
   int         popCount = 0;
   bit         randomReady = 1'b0;
   bit         tbToggle = 1'b0;

   logic [7:0] expData [$];
   bit         expLast [$];
   logic [7:0] savedData [$];
   bit         savedLast [$];
   logic [7:0] monByte;
   bit         monLast;
   int         payloadLen;

   usb_in_packet_gen #(.MAX_PACKET_SIZE(TB_MAX)) dut (
      .clk12_i               (clock),
      .rst_n_i               (rst_n),
      .start_i               (startIn),
      .ack_i                 (ackIn),
      .timeout_i             (timeoutIn),
      .toggleReset_i         (toggleResetIn),
      .fifoDataAvailable_i   (fifoAvail),
      .fifoData_i            (fifoData),
      .fifoPop_o             (fifoPop),
      .fifoPopTransDone_o    (transDone),
      .fifoPopTransSuccess_o (transSuccess),
      .txValid_o             (txValid),
      .txData_o              (txData),
      .txIsLast_o            (txLast),
      .txReady_i             (txReady),
      .busy_o                (busy),
      .dataToggle_o          (dataToggle)
   );

   assign fifoAvail = (rdPtr < wrPtr);
   assign fifoData  = fifoMem[rdPtr[7:0]];

   // Free-running 12 MHz-style clock
   initial begin
      forever #5 clock = ~clock;
   end

   // Serializer ready: always on, or a coin flip per cycle when backpressure is wanted
   initial begin
      txReady = 1'b1;
      forever begin
         @(posedge clock);
         #1;
         txReady = randomReady ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
   end

   // Single comparison point: counts every check and reports any mismatch
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Mid-cycle monitor: note FIFO pops/handshakes and score every accepted tx byte
   always @(negedge clock) begin
      popSeen     = fifoPop;
      doneSeen    = transDone;
      successSeen = transSuccess;
      if (fifoPop) begin
         popCount++;
      end
      if (txValid && txReady) begin
         if (expData.size() == 0) begin
            checkOutput("spuriousTxByte", 32'(txData), 32'h100);
         end else begin
            monByte = expData.pop_front();
            monLast = expLast.pop_front();
            checkOutput("txData", 32'(txData), 32'(monByte));
            checkOutput("txIsLast", 32'(txLast), 32'(monLast));
         end
      end
   end

   // FIFO pointer model: pops advance the head, TransDone commits or rolls back
   always @(posedge clock) begin
      if (fifoFlush) begin
         rdPtr      <= wrPtr;
         transStart <= wrPtr;
      end else begin
         if (popSeen) begin
            rdPtr <= rdPtr + 1;
         end
         if (doneSeen) begin
            if (successSeen) begin
               transStart <= rdPtr;
            end else begin
               rdPtr <= transStart;
            end
         end
      end
   end

   // Append n committed bytes (sequential from base, or random) to the FIFO
   task automatic loadFifo(input int n, input logic [7:0] base, input bit randomBytes);
      for (int i = 0; i < n; i++) begin
         fifoMem[wrPtr[7:0]] = randomBytes ? 8'($urandom_range(0, 255)) : base + 8'(i);
         wrPtr++;
      end
   endtask

   task automatic pushByte(input logic [7:0] b, input bit last);
      expData.push_back(b);
      expLast.push_back(last);
   endtask

   // Expected packet built from the FIFO model with a bit-serial CRC16
   task automatic pushModelPacket(output int nPay);
      int         avail;
      int         idx;
      logic [15:0] crc;
      logic [7:0] b;
      bit         fb;
      avail = wrPtr - rdPtr;
      nPay  = (avail > TB_MAX) ? TB_MAX : avail;
      crc   = 16'hFFFF;
      pushByte(tbToggle ? 8'h4B : 8'hC3, 1'b0);
      for (int i = 0; i < nPay; i++) begin
         idx = (rdPtr + i) % 256;
         b   = fifoMem[idx];
         pushByte(b, 1'b0);
         for (int j = 0; j < 8; j++) begin
            fb  = crc[0] ^ b[j];
            crc = crc >> 1;
            if (fb) begin
               crc = crc ^ 16'hA001;
            end
         end
      end
      crc = ~crc;
      pushByte(crc[7:0], 1'b0);
      pushByte(crc[15:8], 1'b1);
   endtask

   // One full packet: start, drain the expected bytes, then hand back ACK or timeout
   task automatic applyStimulus(input bit useAck, input bit withToggleReset, input int expPops);
      int waitCycles;
      popCount = 0;
      startIn  = 1'b1;
      @(posedge clock);
      #1;
      startIn = 1'b0;
      waitCycles = 0;
      while (expData.size() != 0 && waitCycles < 3000) begin
         @(negedge clock);
         waitCycles++;
      end
      if (expData.size() != 0) begin
         checkOutput("drainTimeout", 32'(expData.size()), 32'd0);
         expData.delete();
         expLast.delete();
      end
      @(posedge clock);
      #1;
      checkOutput("popCount", 32'(popCount), 32'(expPops));
      checkOutput("busyWaitHs", 32'(busy), 32'd1);
      ackIn         = useAck;
      timeoutIn     = !useAck;
      toggleResetIn = withToggleReset;
      @(posedge clock);
      #1;
      ackIn         = 1'b0;
      timeoutIn     = 1'b0;
      toggleResetIn = 1'b0;
      if (withToggleReset) begin
         tbToggle = 1'b0;
      end else if (useAck) begin
         tbToggle = ~tbToggle;
      end
      waitCycles = 0;
      while (!transDone && waitCycles < 10) begin
         @(negedge clock);
         waitCycles++;
      end
      checkOutput("transDone", 32'(transDone), 32'd1);
      checkOutput("transSuccess", 32'(transSuccess), 32'(useAck));
      checkOutput("dataToggle", 32'(dataToggle), 32'(tbToggle));
      @(posedge clock);
      #1;
      checkOutput("transDonePulse", 32'(transDone), 32'd0);
      checkOutput("busyIdle", 32'(busy), 32'd0);
   endtask

   // Pulse toggleReset while idle and confirm DATA0 is selected
   task automatic pulseToggleReset();
      toggleResetIn = 1'b1;
      @(posedge clock);
      #1;
      toggleResetIn = 1'b0;
      tbToggle = 1'b0;
      checkOutput("toggleResetIdle", 32'(dataToggle), 32'd0);
   endtask

   // Test sequence
   initial begin
      rst_n         = 1'b0;
      startIn       = 1'b0;
      ackIn         = 1'b0;
      timeoutIn     = 1'b0;
      toggleResetIn = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("resetBusy", 32'(busy), 32'd0);
      checkOutput("resetTxValid", 32'(txValid), 32'd0);
      checkOutput("resetTxData", 32'(txData), 32'd0);
      checkOutput("resetFifoPop", 32'(fifoPop), 32'd0);
      checkOutput("resetTransDone", 32'(transDone), 32'd0);
      checkOutput("resetToggle", 32'(dataToggle), 32'd0);
      rst_n = 1'b1;
      @(posedge clock);
      #1;

      $display("[TB] zero-length packet");
      pushByte(8'hC3, 1'b0);
      pushByte(8'h00, 1'b0);
      pushByte(8'h00, 1'b1);
      applyStimulus(1'b1, 1'b0, 0);

      $display("[TB] stray ACK while idle");
      ackIn = 1'b1;
      @(posedge clock);
      #1;
      ackIn = 1'b0;
      @(posedge clock);
      #1;
      checkOutput("strayAckDone", 32'(transDone), 32'd0);
      checkOutput("strayAckToggle", 32'(dataToggle), 32'(tbToggle));

      $display("[TB] check string packet");
      pulseToggleReset();
      loadFifo(9, 8'h31, 1'b0);
      pushByte(8'hC3, 1'b0);
      for (int i = 0; i < 9; i++) begin
         pushByte(8'h31 + 8'(i), 1'b0);
      end
      pushByte(8'hC8, 1'b0);
      pushByte(8'hB4, 1'b1);
      applyStimulus(1'b1, 1'b0, 9);

      $display("[TB] max packet size split");
      pulseToggleReset();
      loadFifo(70, 8'h00, 1'b1);
      pushModelPacket(payloadLen);
      applyStimulus(1'b1, 1'b0, TB_MAX);
      pushModelPacket(payloadLen);
      applyStimulus(1'b1, 1'b0, 6);

      $display("[TB] timeout and retransmit");
      loadFifo(5, 8'hA0, 1'b0);
      pushModelPacket(payloadLen);
      savedData = expData;
      savedLast = expLast;
      applyStimulus(1'b0, 1'b0, 5);
      expData = savedData;
      expLast = savedLast;
      applyStimulus(1'b1, 1'b0, 5);

      $display("[TB] random backpressure");
      randomReady = 1'b1;
      loadFifo(40, 8'h00, 1'b1);
      pushModelPacket(payloadLen);
      applyStimulus(1'b1, 1'b0, 40);
      randomReady = 1'b0;

      $display("[TB] toggleReset with ACK");
      loadFifo(4, 8'h10, 1'b0);
      pushModelPacket(payloadLen);
      applyStimulus(1'b1, 1'b1, 4);
      loadFifo(2, 8'h20, 1'b0);
      pushModelPacket(payloadLen);
      applyStimulus(1'b1, 1'b0, 2);

      $display("[TB] async reset mid-packet");
      loadFifo(20, 8'h50, 1'b0);
      pushModelPacket(payloadLen);
      popCount = 0;
      startIn  = 1'b1;
      @(posedge clock);
      #1;
      startIn = 1'b0;
      for (int i = 0; i < 200 && popCount < 4; i++) begin
         @(negedge clock);
      end
      checkOutput("midPacketPops", 32'(popCount >= 4), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("asyncBusy", 32'(busy), 32'd0);
      checkOutput("asyncTxValid", 32'(txValid), 32'd0);
      checkOutput("asyncTxData", 32'(txData), 32'd0);
      checkOutput("asyncFifoPop", 32'(fifoPop), 32'd0);
      checkOutput("asyncTransDone", 32'(transDone), 32'd0);
      checkOutput("asyncToggle", 32'(dataToggle), 32'd0);
      expData.delete();
      expLast.delete();
      tbToggle = 1'b0;
      @(posedge clock);
      #1;
      fifoFlush = 1'b1;
      @(posedge clock);
      #1;
      fifoFlush = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      checkOutput("postResetDone", 32'(transDone), 32'd0);
      loadFifo(3, 8'h70, 1'b0);
      pushModelPacket(payloadLen);
      applyStimulus(1'b1, 1'b0, 3);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
